fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: fetch address after reset.
REQ-002 SHALL have one clock; reset is synchronous and active-high, both taken from port ctrl_bus (ctrl_bus_if.central) as ctrl_bus.clk and ctrl_bus.reset.
REQ-003 SHALL have these ports:
- ctrl_bus.clk  input  1  clock, rising edge
- ctrl_bus.reset  input  1  synchronous active-high reset
- stall_d  input  1  decode stall from hazard unit
- redirect  input  1  taken branch/jump resolved in decode
- redirect_pc  input  32  redirect target
- imem_req  output  1  instruction memory request
- imem_addr  output  32  request address
- imem_ack  input  1  request completes this cycle; same-cycle ack legal
- imem_rdata  input  32  instruction, valid with imem_ack
- inst_f  output  32  instruction to IF/ID register data input
- pc_f  output  32  address of current fetch
- pc_plus4_f  output  32  pc_f + 4, modulo 2^32
- if_id_enab  output  1  IF/ID register enable
- if_id_flush  output  1  IF/ID register reset (loads nop 32'h0000_0020)

Function
REQ-004 SHALL implement states FETCH, DRAIN, HOLD.
REQ-005 Handshake SHALL be: once imem_req rises, imem_req and imem_addr stay constant until the cycle imem_ack=1.
REQ-006 FETCH SHALL drive imem_req=1, imem_addr=pc_f, inst_f=imem_rdata.
REQ-007 FETCH, ack=1, stall_d=0, redirect=0 SHALL deliver: if_id_enab=1, pc_f<=pc_f+4, stay FETCH.
REQ-008 FETCH, ack=1, stall_d=1, redirect=0 SHALL latch imem_rdata into hold buffer, go HOLD, if_id_enab=0, pc_f unchanged.
REQ-009 FETCH, ack=0, stall_d=0, redirect=0 SHALL insert bubble: if_id_flush=1.
REQ-010 HOLD SHALL drive imem_req=0, inst_f=hold buffer; on stall_d=0 deliver (if_id_enab=1, pc_f<=pc_f+4, go FETCH).
REQ-011 redirect=1 SHALL take priority over stall_d in every state: if_id_flush=1, if_id_enab=0, pc_f<={redirect_pc[31:2],2'b00}.
REQ-012 redirect in FETCH with ack=1, or in HOLD, SHALL discard the instruction and go FETCH.
REQ-013 redirect in FETCH with ack=0 SHALL latch old pc_f as drain address and go DRAIN.
REQ-014 DRAIN SHALL keep imem_req=1 at the drain address, discard imem_rdata, drive if_id_flush=!stall_d, go FETCH on ack; a further redirect in DRAIN SHALL only update pc_f.
REQ-015 if_id_enab and if_id_flush SHALL never both be 1; with stall_d=1 and redirect=0 both SHALL be 0.
REQ-016 pc_f+4 SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000.

Reset
REQ-017 With ctrl_bus.reset=1 at a rising edge: state<=FETCH, pc_f<=RESET_PC, hold buffer<=32'h0000_0020, drain address<=0.
REQ-018 While ctrl_bus.reset=1: imem_req=0, if_id_enab=0, if_id_flush=1.
REQ-019 Reset mid-request SHALL abandon the outstanding request; memory shares the reset.

Configuration
REQ-020 With FETCH_PERF_EN defined: 32-bit outputs bubble_cnt (+1 per REQ-009 or DRAIN bubble cycle) and redirect_cnt (+1 per redirect cycle), saturating at 32'hFFFF_FFFF, cleared by reset.
REQ-021 Without FETCH_PERF_EN: counters and ports absent; all other behaviour identical.

Verification
REQ-022 Reset release, RESET_PC=0, ack always 1, stall_d=0 -> imem_addr 0,4,8 in consecutive cycles; if_id_enab=1 each cycle.
REQ-023 ack delayed 3 cycles at pc 0x40 -> imem_addr=0x40 held 3 cycles, if_id_flush=1 for 2 cycles, deliver on 3rd, then addr 0x44.
REQ-024 stall_d=1 for 4 cycles at ack of 0x10 (rdata 0x8C22_0000) -> HOLD, imem_req=0, inst_f=0x8C22_0000 held, enab=0/flush=0; delivered when stall_d falls, next addr 0x14.
REQ-025 redirect=1, redirect_pc=0x203, while request at 0x20 unacked -> DRAIN at 0x20 until ack, data discarded, then imem_addr=0x200; flush=1 in redirect cycle.
REQ-026 redirect and stall_d both 1 in HOLD -> flush=1, enab=0, next imem_addr=redirect target.
REQ-027 pc_f=0xFFFF_FFFC delivered -> next imem_addr=0x0000_0000; with FETCH_PERF_EN, bubble_cnt matches flush cycles counted in REQ-023.

Source files
------------

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// ctrl_bus_if -- shared clock/reset bundle for the fetch stage.
//
// Signals:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//
// Modports:
//   master   drives clk/reset (clock/reset generator)
//   slave    consumes clk/reset
//   central  consumes clk/reset (used by fetch_unit)
// ---------------------------------------------------------------------------
interface ctrl_bus_if;
  logic clk;
  logic reset;

  modport master  (output clk, output reset);
  modport slave   (input  clk, input  reset);
  modport central (input  clk, input  reset);
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- instruction fetch stage with an instruction-memory
// request/ack handshake, a decode-stall hold buffer and redirect handling.
//
// States:
//   FETCH  request at pc_f, pass instruction straight through to IF/ID
//   HOLD   instruction arrived while decode stalled; replay it from buffer
//   DRAIN  redirect arrived with a request still open; finish that request
//          at its original address and throw the data away
//
// Ports:
//   ctrl_bus     ctrl_bus_if.central (clk, synchronous active-high reset)
//   stall_d      decode stall from hazard unit
//   redirect     taken branch/jump resolved in decode
//   redirect_pc  redirect target (low two bits ignored)
//   imem_req     instruction memory request
//   imem_addr    request address
//   imem_ack     request completes this cycle (same-cycle ack allowed)
//   imem_rdata   instruction data, valid with imem_ack
//   inst_f       instruction to IF/ID data input
//   pc_f         address of current fetch
//   pc_plus4_f   pc_f + 4, wraps modulo 2^32
//   if_id_enab   IF/ID register enable
//   if_id_flush  IF/ID register reset (loads nop 32'h0000_0020)
//
// Optional feature (macro FETCH_PERF_EN):
//   bubble_cnt   saturating count of bubble cycles
//   redirect_cnt saturating count of redirect cycles
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  ctrl_bus_if.central ctrl_bus,
  input  logic        stall_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_f,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  output logic        if_id_enab,
`ifdef FETCH_PERF_EN
  output logic        if_id_flush,
  output logic [31:0] bubble_cnt,
  output logic [31:0] redirect_cnt
`else
  output logic        if_id_flush
`endif
);

  localparam logic [31:0] NOP_INST = 32'h0000_0020;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t      state_r, state_next;
  logic [31:0] pc_r, pc_next;
  logic [31:0] hold_buf_r, hold_buf_next;
  logic [31:0] drain_addr_r, drain_addr_next;
  logic [31:0] redirect_target;

  // Targets are word aligned; the low bits of redirect_pc are dropped.
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;
  assign pc_f            = pc_r;
  assign pc_plus4_f      = pc_r + 32'd4;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge ctrl_bus.clk) begin
    if (ctrl_bus.reset) begin
      state_r      <= ST_FETCH;
      pc_r         <= RESET_PC;
      hold_buf_r   <= NOP_INST;
      drain_addr_r <= 32'h0000_0000;
    end else begin
      state_r      <= state_next;
      pc_r         <= pc_next;
      hold_buf_r   <= hold_buf_next;
      drain_addr_r <= drain_addr_next;
    end
  end

  // Next-state and next-datapath logic; redirect outranks stall everywhere.
  always_comb begin
    state_next      = state_r;
    pc_next         = pc_r;
    hold_buf_next   = hold_buf_r;
    drain_addr_next = drain_addr_r;
    case (state_r)
      ST_FETCH: begin
        if (redirect) begin
          pc_next = redirect_target;
          if (imem_ack) begin
            state_next = ST_FETCH;
          end else begin
            // Request still open: remember its address so it can complete
            // unchanged before the new target is requested.
            drain_addr_next = pc_r;
            state_next      = ST_DRAIN;
          end
        end else if (imem_ack && !stall_d) begin
          pc_next = pc_plus4_f;
        end else if (imem_ack && stall_d) begin
          hold_buf_next = imem_rdata;
          state_next    = ST_HOLD;
        end else begin
          state_next = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          pc_next    = redirect_target;
          state_next = ST_FETCH;
        end else if (!stall_d) begin
          pc_next    = pc_plus4_f;
          state_next = ST_FETCH;
        end else begin
          state_next = ST_HOLD;
        end
      end
      ST_DRAIN: begin
        // A further redirect only retargets pc; the drain address is fixed.
        if (redirect) begin
          pc_next = redirect_target;
        end else begin
          pc_next = pc_r;
        end
        if (imem_ack) begin
          state_next = ST_FETCH;
        end else begin
          state_next = ST_DRAIN;
        end
      end
      default: begin
        state_next = ST_FETCH;
      end
    endcase
  end

  // Output decode; reset forces a flushed, idle front end.
  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = pc_r;
    inst_f      = hold_buf_r;
    if_id_enab  = 1'b0;
    if_id_flush = 1'b0;
    if (ctrl_bus.reset) begin
      if_id_flush = 1'b1;
    end else begin
      case (state_r)
        ST_FETCH: begin
          imem_req  = 1'b1;
          imem_addr = pc_r;
          inst_f    = imem_rdata;
          if (redirect) begin
            if_id_flush = 1'b1;
          end else if (!stall_d) begin
            if_id_enab  = imem_ack;
            if_id_flush = !imem_ack;
          end else begin
            if_id_enab  = 1'b0;
          end
        end
        ST_HOLD: begin
          imem_req = 1'b0;
          inst_f   = hold_buf_r;
          if (redirect) begin
            if_id_flush = 1'b1;
          end else begin
            if_id_enab = !stall_d;
          end
        end
        ST_DRAIN: begin
          imem_req  = 1'b1;
          imem_addr = drain_addr_r;
          inst_f    = NOP_INST;
          if (redirect) begin
            if_id_flush = 1'b1;
          end else begin
            if_id_flush = !stall_d;
          end
        end
        default: begin
          if_id_flush = 1'b1;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  logic bubble_evt;
  logic redirect_evt;

  // A bubble is a flush not caused by redirect or reset.
  assign bubble_evt   = !ctrl_bus.reset && !redirect && !stall_d &&
                        (((state_r == ST_FETCH) && !imem_ack) ||
                         (state_r == ST_DRAIN));
  assign redirect_evt = !ctrl_bus.reset && redirect;

  // Saturating performance counters.
  always_ff @(posedge ctrl_bus.clk) begin
    if (ctrl_bus.reset) begin
      bubble_cnt   <= 32'h0000_0000;
      redirect_cnt <= 32'h0000_0000;
    end else begin
      if (bubble_evt && (bubble_cnt != 32'hFFFF_FFFF)) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end
      if (redirect_evt && (redirect_cnt != 32'hFFFF_FFFF)) begin
        redirect_cnt <= redirect_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit -- directed self-checking bench for fetch_unit.
// Inputs change just after a rising edge; outputs are checked 1 time unit
// later, well away from the next rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  ctrl_bus_if bus ();

  logic        stall_d;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst_f;
  logic [31:0] pc_f;
  logic [31:0] pc_plus4_f;
  logic        if_id_enab;
  logic        if_id_flush;
`ifdef FETCH_PERF_EN
  logic [31:0] bubble_cnt;
  logic [31:0] redirect_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .ctrl_bus    (bus),
    .stall_d     (stall_d),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_f      (inst_f),
    .pc_f        (pc_f),
    .pc_plus4_f  (pc_plus4_f),
    .if_id_enab  (if_id_enab),
`ifdef FETCH_PERF_EN
    .if_id_flush (if_id_flush),
    .bubble_cnt  (bubble_cnt),
    .redirect_cnt(redirect_cnt)
`else
    .if_id_flush (if_id_flush)
`endif
  );

  initial bus.clk = 1'b0;
  always #5 bus.clk = ~bus.clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge bus.clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic stl,
                       input logic rdr, input logic [31:0] rpc);
    imem_ack    = ack;
    imem_rdata  = rdata;
    stall_d     = stl;
    redirect    = rdr;
    redirect_pc = rpc;
    #1;
  endtask

  task automatic check_ctl(input string tag, input logic req, input logic [31:0] addr,
                           input logic enab, input logic flush);
    check_eq({tag, ".req"},   {31'd0, imem_req},    {31'd0, req});
    check_eq({tag, ".addr"},  imem_addr,            addr);
    check_eq({tag, ".enab"},  {31'd0, if_id_enab},  {31'd0, enab});
    check_eq({tag, ".flush"}, {31'd0, if_id_flush}, {31'd0, flush});
  endtask

  initial begin
    bus.reset = 1'b1;
    drive(1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000);
    tick();
    tick();
    // Reset state
    check_eq("rst.req",   {31'd0, imem_req},    32'd0);
    check_eq("rst.enab",  {31'd0, if_id_enab},  32'd0);
    check_eq("rst.flush", {31'd0, if_id_flush}, 32'd1);
    check_eq("rst.pc",    pc_f,                 32'h0000_0000);
`ifdef FETCH_PERF_EN
    check_eq("rst.bcnt", bubble_cnt,   32'd0);
    check_eq("rst.rcnt", redirect_cnt, 32'd0);
`endif

    // Straight-line fetch, ack every cycle
    bus.reset = 1'b0;
    drive(1'b1, 32'h1111_0000, 1'b0, 1'b0, 32'h0000_0000);
    check_ctl("seq0", 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    check_eq("seq0.inst", inst_f, 32'h1111_0000);
    tick();
    check_ctl("seq1", 1'b1, 32'h0000_0004, 1'b1, 1'b0);
    tick();
    check_ctl("seq2", 1'b1, 32'h0000_0008, 1'b1, 1'b0);
    tick();
    check_eq("seq3.pc4", pc_plus4_f, 32'h0000_0010);

    // Redirect to 0x40 with ack in FETCH: discard, refetch target
    drive(1'b1, 32'h2222_0000, 1'b0, 1'b1, 32'h0000_0040);
    check_ctl("rd40", 1'b1, 32'h0000_000C, 1'b0, 1'b1);
    tick();

    // Ack delayed: two bubble cycles, deliver on the third
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000);
    check_ctl("wait1", 1'b1, 32'h0000_0040, 1'b0, 1'b1);
    tick();
    check_ctl("wait2", 1'b1, 32'h0000_0040, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h3333_0000, 1'b0, 1'b0, 32'h0000_0000);
    check_ctl("wait3", 1'b1, 32'h0000_0040, 1'b1, 1'b0);
    check_eq("wait3.inst", inst_f, 32'h3333_0000);
    tick();
    check_eq("wait.next", imem_addr, 32'h0000_0044);
`ifdef FETCH_PERF_EN
    check_eq("wait.bcnt", bubble_cnt, 32'd2);
`endif

    // Redirect to 0x10, then stall at the ack of 0x10
    drive(1'b1, 32'h4444_0000, 1'b0, 1'b1, 32'h0000_0010);
    tick();
    drive(1'b1, 32'h8C22_0000, 1'b1, 1'b0, 32'h0000_0000);
    check_ctl("stl0", 1'b1, 32'h0000_0010, 1'b0, 1'b0);
    check_eq("stl0.inst", inst_f, 32'h8C22_0000);
    tick();
    for (int i = 1; i < 4; i++) begin
      drive(1'b0, 32'hBAD0_0000 + 32'(i), 1'b1, 1'b0, 32'h0000_0000);
      check_eq("hold.req",   {31'd0, imem_req},    32'd0);
      check_eq("hold.inst",  inst_f,               32'h8C22_0000);
      check_eq("hold.enab",  {31'd0, if_id_enab},  32'd0);
      check_eq("hold.flush", {31'd0, if_id_flush}, 32'd0);
      tick();
    end
    drive(1'b0, 32'hBAD0_0009, 1'b0, 1'b0, 32'h0000_0000);
    check_eq("hold.deliver.enab", {31'd0, if_id_enab}, 32'd1);
    check_eq("hold.deliver.inst", inst_f, 32'h8C22_0000);
    tick();
    drive(1'b1, 32'h5555_0000, 1'b0, 1'b0, 32'h0000_0000);
    check_ctl("hold.next", 1'b1, 32'h0000_0014, 1'b1, 1'b0);

    // Redirect to 0x20, then redirect to 0x203 while 0x20 is unacked
    drive(1'b1, 32'h5555_0000, 1'b0, 1'b1, 32'h0000_0020);
    tick();
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0203);
    check_ctl("drn0", 1'b1, 32'h0000_0020, 1'b0, 1'b1);
    tick();
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000);
    check_ctl("drn1", 1'b1, 32'h0000_0020, 1'b0, 1'b1);
    check_eq("drn1.pc", pc_f, 32'h0000_0200);
    tick();
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0000_0000);
    check_ctl("drn2", 1'b1, 32'h0000_0020, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h6666_0000, 1'b1, 1'b0, 32'h0000_0000);
    check_ctl("drn.next", 1'b1, 32'h0000_0200, 1'b0, 1'b0);
`ifdef FETCH_PERF_EN
    check_eq("drn.bcnt", bubble_cnt, 32'd4);
`endif
    tick();

    // Redirect and stall together in HOLD
    drive(1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0300);
    check_ctl("hrd", 1'b0, 32'h0000_0200, 1'b0, 1'b1);
    tick();
    drive(1'b1, 32'h7777_0000, 1'b0, 1'b1, 32'hFFFF_FFFC);
    check_eq("hrd.next", imem_addr, 32'h0000_0300);
    tick();

    // Wrap at the top of the address space
    drive(1'b1, 32'h8888_0000, 1'b0, 1'b0, 32'h0000_0000);
    check_ctl("wrap0", 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    check_eq("wrap0.pc4", pc_plus4_f, 32'h0000_0000);
    tick();
    check_eq("wrap1.addr", imem_addr, 32'h0000_0000);
`ifdef FETCH_PERF_EN
    check_eq("end.rcnt", redirect_cnt, 32'd6);
    check_eq("end.bcnt", bubble_cnt,   32'd4);
`endif
    tick();

    // Reset in the middle of an open request
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0500);
    tick();
    bus.reset = 1'b1;
    drive(1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000);
    check_ctl("mrst", 1'b0, 32'h0000_0500, 1'b0, 1'b1);
    tick();
    bus.reset = 1'b0;
    drive(1'b1, 32'h9999_0000, 1'b0, 1'b0, 32'h0000_0000);
    check_ctl("mrst.after", 1'b1, 32'h0000_0000, 1'b1, 1'b0);
`ifdef FETCH_PERF_EN
    check_eq("mrst.rcnt", redirect_cnt, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
